speaker_melody_seq: RTL

- Bus-programmable melody sequencer that drives the speaker tone datapath. It replaces static tone-index writes with a timed note sequence.
- Software loads a note table and a tempo through naive_bus, then issues START. The block steps through the table and presents one tone index at a time, holding each for its duration in tempo ticks, with a one-tick rest between notes.
- Its note_idx output feeds the speaker block's tone-index input (INX) directly. A value of 0 means silence.

---
 rtl/speaker_seq_pkg.sv | 16 +
 rtl/naive_bus.sv | 8 +
 rtl/speaker_tick_gen.sv | 20 ++
 rtl/speaker_melody_seq.sv | 115 +++++++++++
 4 files changed

// File: rtl/speaker_seq_pkg.sv
// speaker_seq_pkg: shared types and register map for the melody sequencer.
package speaker_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_TEMPO  = 8'h08;
  localparam logic [7:0] REG_LEN    = 8'h0C;
  localparam logic [7:0] TABLE_BASE = 8'h80;
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;
  typedef struct packed {
    logic [7:0] dur;
    logic [7:0] note;
  } note_t;
endpackage

// File: rtl/naive_bus.sv
// naive_bus: simple request/grant register bus with byte addressing.
// master drives requests, addresses and write data; slave returns grants and read data.
interface naive_bus;
  logic        rd_req, rd_gnt, wr_req, wr_gnt;
  logic [31:0] rd_addr, wr_addr, wr_data, rd_data;
  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, input rd_gnt, wr_gnt, rd_data);
  modport slave  (input rd_req, rd_addr, wr_req, wr_addr, wr_data, output rd_gnt, wr_gnt, rd_data);
endinterface

// File: rtl/speaker_tick_gen.sv
// speaker_tick_gen: tempo counter producing one tick every `tempo` cycles.
// Ports: CLK0/RST0 clock and async active-low reset; en counts when high;
// clr forces the count to 0; tempo period in cycles (>=1); tick marks the last cycle of a period.
module speaker_tick_gen (
  input  logic        CLK0,
  input  logic        RST0,
  input  logic        en,
  input  logic        clr,
  input  logic [23:0] tempo,
  output logic        tick
);
  logic [23:0] cnt;
  logic        wrap;
  // >= rather than == so a shortened tempo written mid-period wraps immediately
  assign wrap = cnt >= tempo - 24'd1;
  assign tick = en & ~clr & wrap;
  always_ff @(posedge CLK0 or negedge RST0)
    if (!RST0) cnt <= '0;
    else cnt <= (!en || clr || wrap) ? '0 : cnt + 24'd1;
endmodule

// File: rtl/speaker_melody_seq.sv
// speaker_melody_seq: bus-programmable melody sequencer feeding the speaker tone index.
// Ports: CLK0/RST0 clock and async active-low reset; bus register/table slave;
// note_idx current tone (0 = rest); busy while playing; done_pulse at end of a non-loop sequence.
module speaker_melody_seq
  import speaker_seq_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int TEMPO_RST = 6250000
) (
  input  logic       CLK0,
  input  logic       RST0,
  naive_bus.slave    bus,
  output logic [7:0] note_idx,
  output logic       busy,
  output logic       done_pulse
);
  localparam int AW = $clog2(DEPTH);
  state_t      state, state_nxt, eos_state;
  logic [7:0]  idx, idx_nxt, eos_idx, rem, rem_nxt, note_nxt;
  logic [7:0]  waddr, raddr;
  logic [23:0] tempo;
  logic [8:0]  len;
  logic        loop, wr_ctrl, start, stop, tick, last;
  logic [31:0] rd_mux;
  note_t       tbl [DEPTH];
  note_t       cur;
  logic        unused;
  assign unused = ^{bus.wr_addr[31:8], bus.rd_addr[31:8], bus.wr_data[31:24]};
  assign waddr = bus.wr_addr[7:0];
  assign raddr = bus.rd_addr[7:0];
  assign bus.rd_gnt = bus.rd_req;
  assign bus.wr_gnt = bus.wr_req;
  assign wr_ctrl = bus.wr_req && waddr == REG_CTRL;
  assign stop = wr_ctrl && bus.wr_data[CTRL_STOP];
  assign start = wr_ctrl && bus.wr_data[CTRL_START] && !stop && len != '0;
  assign busy = state inside {LOAD, PLAY, GAP};
  assign done_pulse = state == DONE;
  assign cur = tbl[idx[AW-1:0]];
  // compared as "at or beyond" so a shrinking LEN ends the sequence at the next check
  assign last = {1'b0, idx} + 9'd1 >= len;
  assign eos_state = last ? (loop ? LOAD : DONE) : LOAD;
  assign eos_idx = last ? 8'd0 : idx + 8'd1;
  speaker_tick_gen u_tick (
    .CLK0  (CLK0),
    .RST0  (RST0),
    .en    (state != IDLE),
    .clr   (start || state == LOAD),
    .tempo (tempo),
    .tick  (tick)
  );
  always_ff @(posedge CLK0 or negedge RST0)
    if (!RST0) begin
      tempo <= 24'(TEMPO_RST);
      len <= '0;
      loop <= 1'b0;
    end else if (bus.wr_req) begin
      if (waddr == REG_CTRL) loop <= bus.wr_data[CTRL_LOOP];
      if (waddr == REG_TEMPO) tempo <= bus.wr_data[23:0] == '0 ? 24'd1 : bus.wr_data[23:0];
      if (waddr == REG_LEN) len <= bus.wr_data > 32'(DEPTH) ? 9'(DEPTH) : bus.wr_data[8:0];
    end
  always_ff @(posedge CLK0)
    if (bus.wr_req && waddr >= TABLE_BASE) tbl[bus.wr_addr[AW+1:2]] <= bus.wr_data[15:0];
  assign rd_mux = raddr >= TABLE_BASE ? {16'd0, tbl[bus.rd_addr[AW+1:2]]} :
                  raddr == REG_STATUS ? {8'd0, note_idx, idx, 6'd0, loop, busy} :
                  raddr == REG_TEMPO  ? {8'd0, tempo} :
                  raddr == REG_LEN    ? {23'd0, len} : '0;
  always_ff @(posedge CLK0 or negedge RST0)
    if (!RST0) bus.rd_data <= '0;
    else if (bus.rd_req) bus.rd_data <= rd_mux;
  always_ff @(posedge CLK0 or negedge RST0)
    if (!RST0) begin
      state <= IDLE;
      idx <= '0;
      rem <= '0;
      note_idx <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      rem <= rem_nxt;
      note_idx <= note_nxt;
    end
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    rem_nxt = rem;
    if (stop) state_nxt = IDLE;
    else if (start) begin
      state_nxt = LOAD;
      idx_nxt = '0;
    end else
      case (state)
        LOAD:
          if (cur.dur != '0) begin
            state_nxt = PLAY;
            rem_nxt = cur.dur;
          end else begin
            state_nxt = eos_state;
            idx_nxt = eos_idx;
          end
        PLAY:
          if (tick) begin
            rem_nxt = rem - 8'd1;
            state_nxt = rem == 8'd1 ? GAP : PLAY;
          end
        GAP:
          if (tick) begin
            state_nxt = eos_state;
            idx_nxt = eos_idx;
          end
        default: state_nxt = IDLE;
      endcase
    // the tone is latched only on LOAD->PLAY, so table writes mid-note do not disturb it
    note_nxt = (state == LOAD && state_nxt == PLAY) ? cur.note : state_nxt == PLAY ? note_idx : 8'd0;
  end
endmodule
